adder_bist: RTL and testbench
=============================

ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 Parameters: WIDTH, 12, operand/result width; N_VECTORS, 256, vectors per run (1..4096); SETTLE_CYCLES, 2, extra hold cycles before sampling (0..15); B_OFFSET, 12'h001, constant added to vector index to form op_b.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a test run; sampled only in IDLE.
REQ-005 op_a  output  WIDTH  operand A driven to the adder under test.
REQ-006 op_b  output  WIDTH  operand B driven to the adder under test.
REQ-007 op_c  input  WIDTH  sum returned by the adder under test.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  high from run completion until next accepted start or reset.
REQ-010 pass  output  1  high with done when err_count equals 0.
REQ-011 err_count  output  8  mismatches in current/last run, saturating at 255.
REQ-012 first_fail_idx  output  12  index of first mismatching vector; 12'hFFF if none.

Function
REQ-013 FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after last vector compared; DONE->RUN on start=1; no other transitions except reset.
REQ-014 On the edge accepting start: vector index k=0, op_a=0, op_b=B_OFFSET, err_count=0, first_fail_idx=12'hFFF, done=0, pass=0, busy=1.
REQ-015 Vector k: op_a = k mod 2^WIDTH; op_b = (k + B_OFFSET) mod 2^WIDTH; expected = (op_a + op_b) mod 2^WIDTH, carry discarded.
REQ-016 Each vector held stable for exactly SETTLE_CYCLES+1 cycles; hold counter counts 0..SETTLE_CYCLES.
REQ-017 op_c compared against expected on the edge ending the hold window (counter = SETTLE_CYCLES); on the same edge op_a/op_b advance to vector k+1.
REQ-018 Mismatch: err_count increments unless already 255; first_fail_idx loads k only if it currently holds 12'hFFF.
REQ-019 op_c sampled only at compare edges; values at other cycles have no effect.
REQ-020 After compare of vector N_VECTORS-1: state DONE, busy=0, done=1, pass=(err_count==0 including that last compare), op_a/op_b hold last vector.
REQ-021 Run length from start-accept edge to done rising: exactly N_VECTORS*(SETTLE_CYCLES+1) cycles.
REQ-022 start while in RUN is ignored; start held high in DONE restarts immediately (REQ-014).
REQ-023 Index counter 13 bits wide so N_VECTORS=4096 terminates; operands wrap modulo 4096.

Reset
REQ-024 rst_n=0 asynchronously forces: state IDLE, op_a=0, op_b=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=12'hFFF, hold and index counters 0.
REQ-025 Reset mid-run aborts with no partial result retained; next start restarts from vector 0.
REQ-026 First edge after rst_n deasserts may accept start.

Verification
REQ-027 Ideal adder model, defaults, start pulse 1 cycle -> busy 768 cycles, then done=1, pass=1, err_count=0, first_fail_idx=12'hFFF.
REQ-028 Model with op_c[0] stuck at 0, defaults (every sum 2k+1 odd) -> err_count=255 (saturated), first_fail_idx=0, pass=0.
REQ-029 Model wrong only when op_a=12'h07F (force op_c=0), defaults -> err_count=1, first_fail_idx=12'h07F, pass=0.
REQ-030 N_VECTORS=4096, B_OFFSET=12'hFFF, SETTLE_CYCLES=0, ideal model -> vector 1 gives op_b=12'h000, expected 12'h001; run lasts 4096 cycles; pass=1.
REQ-031 Start re-pulsed at vector 10 -> ignored, run length unchanged; rst_n pulsed low at vector 10 -> outputs per REQ-024 immediately, fresh start restarts at op_a=0.
REQ-032 Model with 2-cycle combinational delay, SETTLE_CYCLES=2 -> pass=1; SETTLE_CYCLES=0 -> pass=0, first_fail_idx=0.

Source files
------------

// File: rtl/adder_bist.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adder_bist: walks N_VECTORS operand pairs through an external adder and
// tallies mismatches.                                           Rev 1.0
// ----------------------------------------------------------------------------
module adder_bist #(
  parameter int                WIDTH         = 12,
  parameter int                N_VECTORS     = 256,
  parameter int                SETTLE_CYCLES = 2,
  parameter logic [WIDTH-1:0]  B_OFFSET      = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] op_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [11:0]      first_fail_idx
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [12:0] LAST_IDX  = 13'(N_VECTORS - 1);
  localparam logic [3:0]  HOLD_LAST = 4'(SETTLE_CYCLES);
  localparam logic [11:0] NO_FAIL   = 12'hFFF;

  state_t           state_q, state_d;
  logic [12:0]      idx_q, idx_d;
  logic [3:0]       hold_q, hold_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [7:0]       err_q, err_d;
  logic [11:0]      ffi_q, ffi_d;
  logic             done_q, done_d, pass_q, pass_d;

  logic [WIDTH-1:0] next_k, expected;
  logic             compare, mismatch;
  logic [7:0]       err_upd;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    err_d    = err_q;
    ffi_d    = ffi_q;
    done_d   = done_q;
    pass_d   = pass_q;
    next_k   = WIDTH'(idx_q + 13'd1);
    expected = op_a_q + op_b_q;
    compare  = (state_q == RUN) && (hold_q == HOLD_LAST);
    mismatch = compare && (op_c != expected);
    err_upd  = (mismatch && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          idx_d   = '0;
          hold_d  = '0;
          op_a_d  = '0;
          op_b_d  = B_OFFSET;
          err_d   = '0;
          ffi_d   = NO_FAIL;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (!compare) begin
          hold_d = hold_q + 4'd1;
        end else begin
          hold_d = '0;
          err_d  = err_upd;
          if (mismatch && (ffi_q == NO_FAIL)) ffi_d = idx_q[11:0];
          // Last vector: operands stay parked on it while DONE is reported.
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (err_upd == 8'd0);
          end else begin
            idx_d  = idx_q + 13'd1;
            op_a_d = next_k;
            op_b_d = next_k + B_OFFSET;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      err_q   <= '0;
      ffi_q   <= NO_FAIL;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign op_a           = op_a_q;
  assign op_b           = op_b_q;
  assign busy           = (state_q == RUN);
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_bist.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_adder_bist: scoreboard bench driving two adder_bist configurations
// against several adder models.                                Rev 1.0
// ----------------------------------------------------------------------------
module tb_adder_bist;

  typedef struct {
    logic [7:0]  err;
    logic [11:0] ffi;
    logic        pass;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        mode2 = 1'b0;

  logic [11:0] op_a, op_b, op_c, op_a2, op_b2, op_c2;
  logic        busy, done, pass, busy2, done2, pass2;
  logic [7:0]  err_count, err_count2;
  logic [11:0] ffi, ffi2;
  logic [11:0] d1, d2, e1, e2;

  int checks = 0;
  int errors = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  adder_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .op_c(op_c), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(ffi)
  );

  adder_bist #(.WIDTH(12), .N_VECTORS(4096), .SETTLE_CYCLES(0),
               .B_OFFSET(12'hFFF)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op_a(op_a2), .op_b(op_b2),
    .op_c(op_c2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .first_fail_idx(ffi2)
  );

  // Adder models: ideal, bit0 stuck low, wrong at op_a==07F, 2-cycle delay.
  always @(posedge clk) begin
    d1 <= op_a + op_b;
    d2 <= d1;
    e1 <= op_a2 + op_b2;
    e2 <= e1;
  end

  always_comb begin
    op_c = op_a + op_b;
    case (mode)
      2'd1:    op_c = (op_a + op_b) & 12'hFFE;
      2'd2:    op_c = (op_a == 12'h07F) ? 12'h000 : op_a + op_b;
      2'd3:    op_c = d2;
      default: op_c = op_a + op_b;
    endcase
    op_c2 = mode2 ? e2 : op_a2 + op_b2;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop the expected result whenever done rises.
  int   cyc1 = 0, cyc2 = 0;
  logic bp1 = 1'b0, dp1 = 1'b0, bp2 = 1'b0, dp2 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      cyc1 = 0; bp1 = 1'b0; dp1 = 1'b0;
    end else begin
      if (busy && !bp1) cyc1 = 0;
      if (busy) cyc1++;
      if (done && !dp1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut1_unexpected_done: got done=1 expected no run");
        end else begin
          e = q1.pop_front();
          check("dut1_err_count", {24'd0, err_count}, {24'd0, e.err});
          check("dut1_first_fail", {20'd0, ffi}, {20'd0, e.ffi});
          check("dut1_pass", {31'd0, pass}, {31'd0, e.pass});
          check("dut1_run_cycles", cyc1, e.cyc);
        end
      end
      bp1 = busy; dp1 = done;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      cyc2 = 0; bp2 = 1'b0; dp2 = 1'b0;
    end else begin
      if (busy2 && !bp2) cyc2 = 0;
      if (busy2) cyc2++;
      if (done2 && !dp2) begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut2_unexpected_done: got done=1 expected no run");
        end else begin
          e = q2.pop_front();
          check("dut2_err_count", {24'd0, err_count2}, {24'd0, e.err});
          check("dut2_first_fail", {20'd0, ffi2}, {20'd0, e.ffi});
          check("dut2_pass", {31'd0, pass2}, {31'd0, e.pass});
          check("dut2_run_cycles", cyc2, e.cyc);
        end
      end
      bp2 = busy2; dp2 = done2;
    end
  end

  task automatic issue1(input exp_t e, input bit push);
    if (push) q1.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue2(input exp_t e);
    q2.push_back(e);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic wait1(input int limit);
    int n = 0;
    while (!done && n < limit) begin @(negedge clk); n++; end
    if (!done) begin
      checks++; errors++;
      $display("FAIL dut1_timeout: got done=0 expected done within %0d", limit);
    end
    @(negedge clk);
  endtask

  task automatic wait2(input int limit);
    int n = 0;
    while (!done2 && n < limit) begin @(negedge clk); n++; end
    if (!done2) begin
      checks++; errors++;
      $display("FAIL dut2_timeout: got done=0 expected done within %0d", limit);
    end
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_op_a"}, {20'd0, op_a}, 32'h0);
    check({tag, "_op_b"}, {20'd0, op_b}, 32'h0);
    check({tag, "_busy"}, {31'd0, busy}, 32'h0);
    check({tag, "_done"}, {31'd0, done}, 32'h0);
    check({tag, "_pass"}, {31'd0, pass}, 32'h0);
    check({tag, "_err"}, {24'd0, err_count}, 32'h0);
    check({tag, "_ffi"}, {20'd0, ffi}, 32'hFFF);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    // Ideal adder with defaults.
    mode = 2'd0;
    issue1('{8'd0, 12'hFFF, 1'b1, 768}, 1'b1);
    check("accept_busy", {31'd0, busy}, 32'h1);
    check("accept_op_b", {20'd0, op_b}, 32'h001);
    wait1(1000);
    check("done_hold_op_a", {20'd0, op_a}, 32'h0FF);
    check("done_hold_op_b", {20'd0, op_b}, 32'h100);

    // Sum bit 0 stuck low: every sum is odd, so every vector fails.
    mode = 2'd1;
    issue1('{8'd255, 12'h000, 1'b0, 768}, 1'b1);
    wait1(1000);

    // Single bad vector at op_a == 0x07F.
    mode = 2'd2;
    issue1('{8'd1, 12'h07F, 1'b0, 768}, 1'b1);
    wait1(1000);

    // Two-cycle delayed adder still settles within a 3-cycle hold.
    mode = 2'd3;
    issue1('{8'd0, 12'hFFF, 1'b1, 768}, 1'b1);
    wait1(1000);

    // Start re-pulsed at vector 10 is ignored.
    mode = 2'd0;
    issue1('{8'd0, 12'hFFF, 1'b1, 768}, 1'b1);
    repeat (30) @(negedge clk);
    check("restart_ignored_vec10", {20'd0, op_a}, 32'h00A);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_ignored_op_a", {20'd0, op_a}, 32'h00A);
    wait1(1000);

    // Reset mid-run at vector 10 clears everything asynchronously.
    issue1('{8'd0, 12'hFFF, 1'b1, 768}, 1'b0);
    repeat (30) @(negedge clk);
    check("abort_vec10", {20'd0, op_a}, 32'h00A);
    #2 rst_n = 1'b0;
    #1 check_reset("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    issue1('{8'd0, 12'hFFF, 1'b1, 768}, 1'b1);
    check("fresh_start_op_a", {20'd0, op_a}, 32'h000);
    check("fresh_start_op_b", {20'd0, op_b}, 32'h001);
    wait1(1000);

    // Full 4096-vector run, B_OFFSET=FFF, no settle: op_b wraps at vector 1.
    mode2 = 1'b0;
    issue2('{8'd0, 12'hFFF, 1'b1, 4096});
    check("dut2_vec0_op_b", {20'd0, op_b2}, 32'hFFF);
    @(negedge clk);
    check("dut2_vec1_op_a", {20'd0, op_a2}, 32'h001);
    check("dut2_vec1_op_b", {20'd0, op_b2}, 32'h000);
    wait2(5000);

    // Delayed adder with no settle time fails from vector 0 onward.
    mode2 = 1'b1;
    issue2('{8'd255, 12'h000, 1'b0, 4096});
    wait2(5000);

    if (q1.size() != 0 || q2.size() != 0) begin
      checks++; errors++;
      $display("FAIL pending_results: got %0d/%0d expected 0/0", q1.size(), q2.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
